// File: rtl/dma_xfer_sched.sv
// Round-robin DMA transfer scheduler: grant 1 cyc after request, engine released after SETUP_CYC, done 2 cyc after final fire.
// Requests wait (req_valid held) while busy; optional DMA_TIMEOUT_EN aborts a stalled RUN with err alongside done.
module dma_xfer_sched #(
    parameter int LEN_W       = 8,
    parameter int CPU_BEATS   = 8,
    parameter int MEM_BEATS   = 16,
`ifdef DMA_TIMEOUT_EN
    parameter int TIMEOUT_CYC = 1024,
`endif
    parameter int SETUP_CYC   = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [1:0]       req_valid,
    input  logic [1:0]       req_dir,
    input  logic [LEN_W-1:0] req_len0,
    input  logic [LEN_W-1:0] req_len1,
    output logic [1:0]       req_ready,
    output logic [1:0]       done,
    output logic [1:0]       err,
    output logic             busy,
    output logic             dma_mode,
    output logic             dma_resetn,
    input  logic             dma_to_mem_valid,
    input  logic             dma_to_mem_enable,
    input  logic             dma_to_cpu_valid,
    input  logic             dma_to_cpu_enable
);

    localparam int BEAT_W = $clog2(MEM_BEATS);
    localparam int SET_W  = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;

    typedef enum logic [2:0] {IDLE, GRANT, SETUP, RUN, DONE} state_t;

    state_t            state;
    logic              g;
    logic              last_g;
    logic              dir;
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  blk_cnt;
    logic [BEAT_W-1:0] beat_cnt;
    logic [SET_W-1:0]  setup_cnt;
    logic              fire;
    logic              win;
    logic [BEAT_W-1:0] last_beat;
    logic              last_fire;

    assign fire      = dir ? (dma_to_mem_valid & dma_to_mem_enable)
                           : (dma_to_cpu_valid & dma_to_cpu_enable);
    assign last_beat = dir ? BEAT_W'(MEM_BEATS - 1) : BEAT_W'(CPU_BEATS - 1);
    assign last_fire = fire && (beat_cnt == last_beat) && (blk_cnt == len - LEN_W'(1));

    // Contention goes to whoever was not served last.
    always_comb begin
        win = 1'b0;
        if (req_valid == 2'b10)
            win = 1'b1;
        else if (req_valid == 2'b11)
            win = ~last_g;
    end

`ifdef DMA_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT_CYC + 1);
    logic [STALL_W-1:0] stall_cnt;
    logic               timed_out;
    logic               stall_last;
    assign stall_last = !fire && (stall_cnt == STALL_W'(TIMEOUT_CYC - 1));
`else
    assign err = 2'b00;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            req_ready  <= 2'b00;
            done       <= 2'b00;
            busy       <= 1'b0;
            dma_mode   <= 1'b0;
            dma_resetn <= 1'b0;
            last_g     <= 1'b1;
            g          <= 1'b0;
            dir        <= 1'b0;
            len        <= '0;
            blk_cnt    <= '0;
            beat_cnt   <= '0;
            setup_cnt  <= '0;
`ifdef DMA_TIMEOUT_EN
            err        <= 2'b00;
            stall_cnt  <= '0;
            timed_out  <= 1'b0;
`endif
        end else begin
            req_ready <= 2'b00;
            done      <= 2'b00;
`ifdef DMA_TIMEOUT_EN
            err       <= 2'b00;
`endif
            case (state)
                IDLE: begin
                    dma_resetn <= 1'b0;
                    if (|req_valid) begin
                        g         <= win;
                        dir       <= req_dir[win];
                        len       <= win ? req_len1 : req_len0;
                        req_ready <= win ? 2'b10 : 2'b01;
                        busy      <= 1'b1;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    beat_cnt  <= '0;
                    blk_cnt   <= '0;
                    setup_cnt <= '0;
`ifdef DMA_TIMEOUT_EN
                    stall_cnt <= '0;
                    timed_out <= 1'b0;
`endif
                    // A zero-length request completes without ever releasing the engine.
                    if (len == '0) begin
                        state <= DONE;
                    end else begin
                        dma_mode <= dir;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    if (setup_cnt == SET_W'(SETUP_CYC - 1)) begin
                        dma_resetn <= 1'b1;
                        state      <= RUN;
                    end else begin
                        setup_cnt <= setup_cnt + SET_W'(1);
                    end
                end
                RUN: begin
                    if (fire) begin
                        if (beat_cnt == last_beat) begin
                            beat_cnt <= '0;
                            blk_cnt  <= blk_cnt + LEN_W'(1);
                        end else begin
                            beat_cnt <= beat_cnt + BEAT_W'(1);
                        end
                    end
                    if (last_fire) begin
                        dma_resetn <= 1'b0;
                        state      <= DONE;
                    end
`ifdef DMA_TIMEOUT_EN
                    stall_cnt <= fire ? '0 : stall_cnt + STALL_W'(1);
                    if (stall_last) begin
                        timed_out  <= 1'b1;
                        dma_resetn <= 1'b0;
                        state      <= DONE;
                    end
`endif
                end
                DONE: begin
                    done   <= g ? 2'b10 : 2'b01;
`ifdef DMA_TIMEOUT_EN
                    err    <= timed_out ? (g ? 2'b10 : 2'b01) : 2'b00;
`endif
                    last_g <= g;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_xfer_sched.sv
// Scoreboard bench for dma_xfer_sched: stimulus queues expected grant/done events with their cycle stamps.
module tb_dma_xfer_sched;

    logic       clk = 1'b0;
    logic       resetn;
    logic [1:0] req_valid;
    logic [1:0] req_dir;
    logic [7:0] req_len0;
    logic [7:0] req_len1;
    logic [1:0] req_ready;
    logic [1:0] done;
    logic [1:0] err;
    logic       busy;
    logic       dma_mode;
    logic       dma_resetn;
    logic       dma_to_mem_valid;
    logic       dma_to_mem_enable;
    logic       dma_to_cpu_valid;
    logic       dma_to_cpu_enable;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct packed {
        logic [1:0]  rdy;
        logic [1:0]  dn;
        logic [1:0]  er;
        logic [31:0] at;
    } ev_t;

    ev_t exp_q[$];

    dma_xfer_sched #(
`ifdef DMA_TIMEOUT_EN
        .TIMEOUT_CYC(16),
`endif
        .LEN_W(8)
    ) dut (
        .clk               (clk),
        .resetn            (resetn),
        .req_valid         (req_valid),
        .req_dir           (req_dir),
        .req_len0          (req_len0),
        .req_len1          (req_len1),
        .req_ready         (req_ready),
        .done              (done),
        .err               (err),
        .busy              (busy),
        .dma_mode          (dma_mode),
        .dma_resetn        (dma_resetn),
        .dma_to_mem_valid  (dma_to_mem_valid),
        .dma_to_mem_enable (dma_to_mem_enable),
        .dma_to_cpu_valid  (dma_to_cpu_valid),
        .dma_to_cpu_enable (dma_to_cpu_enable)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void expect_ev(input logic [1:0] rdy, input logic [1:0] dn,
                                      input logic [1:0] er, input int at);
        ev_t e;
        e.rdy = rdy;
        e.dn  = dn;
        e.er  = er;
        e.at  = at;
        exp_q.push_back(e);
    endfunction

    // Monitor: every cycle with a pulse on req_ready/done/err must match the next queued event.
    always @(negedge clk) begin
        if (req_ready != 2'b00 || done != 2'b00 || err != 2'b00) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pulse cyc=%0d got ready=%b done=%b err=%b, none expected",
                         cyc, req_ready, done, err);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                if (req_ready !== e.rdy || done !== e.dn || err !== e.er || cyc != int'(e.at)) begin
                    bad++;
                    $display("FAIL event cyc=%0d got ready=%b done=%b err=%b, want ready=%b done=%b err=%b at cyc=%0d",
                             cyc, req_ready, done, err, e.rdy, e.dn, e.er, e.at);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got %0h want %0h", nm, cyc, act, want);
        end
    endtask

    initial begin
        int c0;
        resetn            = 1'b0;
        req_valid         = 2'b00;
        req_dir           = 2'b00;
        req_len0          = 8'd0;
        req_len1          = 8'd0;
        dma_to_mem_valid  = 1'b0;
        dma_to_mem_enable = 1'b0;
        dma_to_cpu_valid  = 1'b0;
        dma_to_cpu_enable = 1'b0;
        tick(3);
        resetn = 1'b1;

        chk("rst_ready", {6'd0, req_ready}, 8'd0);
        chk("rst_done", {6'd0, done}, 8'd0);
        chk("rst_err", {6'd0, err}, 8'd0);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_mode", {7'd0, dma_mode}, 8'd0);
        chk("rst_dma_resetn", {7'd0, dma_resetn}, 8'd0);

        // Tie from reset goes to 0, then the next tie to 1; req0's re-request is withdrawn unserved.
        c0 = cyc;
        req_len0  = 8'd0;
        req_len1  = 8'd0;
        req_valid = 2'b11;
        expect_ev(2'b01, 2'b00, 2'b00, c0 + 1);
        expect_ev(2'b00, 2'b01, 2'b00, c0 + 3);
        expect_ev(2'b10, 2'b00, 2'b00, c0 + 4);
        expect_ev(2'b00, 2'b10, 2'b00, c0 + 6);
        tick(2);
        chk("arb_busy", {7'd0, busy}, 8'd1);
        tick(2);
        req_valid = 2'b00;
        tick(6);

        // Requester 0, cpu->mem, two blocks of 16 nibbles, mem always ready.
        c0 = cyc;
        req_dir           = 2'b01;
        req_len0          = 8'd2;
        dma_to_mem_valid  = 1'b1;
        dma_to_mem_enable = 1'b1;
        req_valid         = 2'b01;
        expect_ev(2'b01, 2'b00, 2'b00, c0 + 1);
        expect_ev(2'b00, 2'b01, 2'b00, c0 + 37);
        tick(1);
        req_valid = 2'b00;
        req_dir   = 2'b00;
        req_len0  = 8'd5;
        tick(2);
        chk("mem_setup_resetn", {7'd0, dma_resetn}, 8'd0);
        chk("mem_setup_mode", {7'd0, dma_mode}, 8'd1);
        tick(1);
        chk("mem_run_resetn", {7'd0, dma_resetn}, 8'd1);
        chk("mem_run_busy", {7'd0, busy}, 8'd1);
        tick(31);
        chk("mem_last_resetn", {7'd0, dma_resetn}, 8'd1);
        tick(1);
        chk("mem_flush_resetn", {7'd0, dma_resetn}, 8'd0);
        tick(4);
        dma_to_mem_valid  = 1'b0;
        dma_to_mem_enable = 1'b0;
        tick(3);

        // Requester 1, mem->cpu, one block of 8 bytes; mode must drop from the previous transfer.
        c0 = cyc;
        req_dir           = 2'b00;
        req_len1          = 8'd1;
        dma_to_cpu_valid  = 1'b1;
        dma_to_cpu_enable = 1'b1;
        req_valid         = 2'b10;
        expect_ev(2'b10, 2'b00, 2'b00, c0 + 1);
        expect_ev(2'b00, 2'b10, 2'b00, c0 + 13);
        tick(1);
        req_valid = 2'b00;
        tick(1);
        chk("cpu_setup_mode0", {7'd0, dma_mode}, 8'd0);
        chk("cpu_setup_resetn", {7'd0, dma_resetn}, 8'd0);
        tick(1);
        chk("cpu_setup_mode1", {7'd0, dma_mode}, 8'd0);
        tick(13);
        dma_to_cpu_valid  = 1'b0;
        dma_to_cpu_enable = 1'b0;
        tick(3);

        // Zero-length request: grant, done two cycles later, engine never released.
        c0 = cyc;
        req_dir   = 2'b01;
        req_len0  = 8'd0;
        req_valid = 2'b01;
        expect_ev(2'b01, 2'b00, 2'b00, c0 + 1);
        expect_ev(2'b00, 2'b01, 2'b00, c0 + 3);
        for (int k = 0; k < 5; k++) begin
            chk("len0_resetn", {7'd0, dma_resetn}, 8'd0);
            if (k == 1) req_valid = 2'b00;
            tick(1);
        end
        tick(3);

        // Reset at beat 5 of a RUN: everything back to reset values, no done afterwards.
        c0 = cyc;
        req_dir           = 2'b01;
        req_len0          = 8'd1;
        dma_to_mem_valid  = 1'b1;
        dma_to_mem_enable = 1'b1;
        req_valid         = 2'b01;
        expect_ev(2'b01, 2'b00, 2'b00, c0 + 1);
        tick(1);
        req_valid = 2'b00;
        tick(8);
        chk("pre_abort_resetn", {7'd0, dma_resetn}, 8'd1);
        resetn = 1'b0;
        tick(1);
        chk("abort_ready", {6'd0, req_ready}, 8'd0);
        chk("abort_done", {6'd0, done}, 8'd0);
        chk("abort_err", {6'd0, err}, 8'd0);
        chk("abort_busy", {7'd0, busy}, 8'd0);
        chk("abort_mode", {7'd0, dma_mode}, 8'd0);
        chk("abort_dma_resetn", {7'd0, dma_resetn}, 8'd0);
        tick(1);
        resetn = 1'b1;
        tick(25);
        chk("abort_stays_idle", {7'd0, busy}, 8'd0);
        dma_to_mem_valid  = 1'b0;
        dma_to_mem_enable = 1'b0;
        tick(2);

`ifdef DMA_TIMEOUT_EN
        // Engine never fires: 16 stalled RUN cycles end the transfer with err.
        c0 = cyc;
        req_dir   = 2'b01;
        req_len0  = 8'd1;
        req_valid = 2'b01;
        expect_ev(2'b01, 2'b00, 2'b00, c0 + 1);
        expect_ev(2'b00, 2'b01, 2'b01, c0 + 21);
        tick(1);
        req_valid = 2'b00;
        tick(25);
`endif

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL pending_events got %0d outstanding want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
